// File: rtl/seq_div16by8.sv
// ============================================================================
// Module   : seq_div16by8
// Purpose  : Sequential restoring divider, 16-bit dividend / 8-bit divisor,
//            one quotient bit per clock, start/done handshake.
// Options  : DIV_ZERO_SHORTCUT_EN - finish a divide-by-zero in one cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_div16by8 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [7:0]  remainder,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_ZERO = 2'd2
  } state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [15:0] q_q;
  logic [7:0]  r_q;
  logic [7:0]  dvsr_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] quot_q;
  logic [7:0]  rem_q;
  logic        dbz_q;

  logic [8:0]  t_d;
  logic [7:0]  r_d;
  logic [15:0] q_d;

  // The partial remainder stays below the divisor, so the subtraction
  // result always fits in 8 bits and only T needs the ninth bit.
  always_comb begin
    t_d = {r_q, q_q[15]};
    r_d = t_d[7:0];
    q_d = {q_q[14:0], 1'b0};
    if (t_d >= {1'b0, dvsr_q}) begin
      r_d = t_d[7:0] - dvsr_q;
      q_d = {q_q[14:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      q_q     <= 16'd0;
      r_q     <= 8'd0;
      dvsr_q  <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= 16'd0;
      rem_q   <= 8'd0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            q_q    <= dividend;
            r_q    <= 8'd0;
            dvsr_q <= divisor;
            cnt_q  <= 5'd0;
            quot_q <= 16'd0;
            rem_q  <= 8'd0;
            dbz_q  <= 1'b0;
            busy_q <= 1'b1;
`ifdef DIV_ZERO_SHORTCUT_EN
            state_q <= (divisor == 8'd0) ? S_ZERO : S_RUN;
`else
            state_q <= S_RUN;
`endif
          end
        end
        S_RUN: begin
          q_q <= q_d;
          r_q <= r_d;
          if (cnt_q == 5'd15) begin
            cnt_q   <= 5'd0;
            quot_q  <= q_d;
            rem_q   <= r_d;
            dbz_q   <= (dvsr_q == 8'd0);
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        S_ZERO: begin
          quot_q  <= 16'hFFFF;
          rem_q   <= q_q[7:0];
          dbz_q   <= 1'b1;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_div16by8.sv
// ============================================================================
// Module   : tb_seq_div16by8
// Purpose  : Self-checking bench for seq_div16by8 against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_div16by8;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int errors = 0;
  int checks = 0;

`ifdef DIV_ZERO_SHORTCUT_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 16;
`endif

  seq_div16by8 dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] m_quot(input int a, input int b);
    if (b == 0) return 16'hFFFF;
    return 16'(a / b);
  endfunction

  function automatic logic [7:0] m_rem(input int a, input int b);
    if (b == 0) return 8'(a % 256);
    return 8'(a % b);
  endfunction

  task automatic start_op(input logic [15:0] a, input logic [7:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; dividend = 16'd1234; divisor = 8'd5;
    idle(2);
    checks += 5;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
    if (quotient !== 16'd0) begin errors++; $display("FAIL rst_quot got %0d want 0", quotient); end
    if (remainder !== 8'd0) begin errors++; $display("FAIL rst_rem got %0d want 0", remainder); end
    if (div_by_zero !== 1'b0) begin errors++; $display("FAIL rst_dbz got %b want 0", div_by_zero); end
    reset = 1'b0; start = 1'b0;
    idle(1);
  endtask

  task automatic test_basic;
    int lat;
    start_op(16'd65025, 8'd255);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy); end
    wait_done(lat);
    checks += 5;
    if (lat != 16) begin errors++; $display("FAIL basic_lat got %0d want 16", lat); end
    if (quotient !== 16'd255) begin errors++; $display("FAIL basic_quot got %0d want 255", quotient); end
    if (remainder !== 8'd0) begin errors++; $display("FAIL basic_rem got %0d want 0", remainder); end
    if (div_by_zero !== 1'b0) begin errors++; $display("FAIL basic_dbz got %b want 0", div_by_zero); end
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %b want 0", busy); end
    idle(1);
    checks += 2;
    if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", done); end
    if (quotient !== 16'd255) begin errors++; $display("FAIL basic_hold got %0d want 255", quotient); end
  endtask

  task automatic test_back_to_back;
    int lat;
    start_op(16'd1000, 8'd7);
    wait_done(lat);
    checks += 3;
    if (lat != 16) begin errors++; $display("FAIL b2b1_lat got %0d want 16", lat); end
    if (quotient !== 16'd142) begin errors++; $display("FAIL b2b1_quot got %0d want 142", quotient); end
    if (remainder !== 8'd6) begin errors++; $display("FAIL b2b1_rem got %0d want 6", remainder); end
    start_op(16'd0, 8'd5);
    checks += 3;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b want 1", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL b2b_done got %b want 0", done); end
    if (quotient !== 16'd0) begin errors++; $display("FAIL b2b_clear got %0d want 0", quotient); end
    wait_done(lat);
    checks += 3;
    if (lat != 16) begin errors++; $display("FAIL b2b2_lat got %0d want 16", lat); end
    if (quotient !== 16'd0) begin errors++; $display("FAIL b2b2_quot got %0d want 0", quotient); end
    if (remainder !== 8'd0) begin errors++; $display("FAIL b2b2_rem got %0d want 0", remainder); end
    idle(2);
  endtask

  task automatic test_div_zero;
    int lat;
    start_op(16'd100, 8'd0);
    wait_done(lat);
    checks += 4;
    if (lat != ZLAT) begin errors++; $display("FAIL dz_lat got %0d want %0d", lat, ZLAT); end
    if (quotient !== 16'hFFFF) begin errors++; $display("FAIL dz_quot got %h want ffff", quotient); end
    if (remainder !== 8'd100) begin errors++; $display("FAIL dz_rem got %0d want 100", remainder); end
    if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_flag got %b want 1", div_by_zero); end
    idle(1);
    start_op(16'd7, 8'd2);
    checks++;
    if (div_by_zero !== 1'b0) begin errors++; $display("FAIL dz_clear got %b want 0", div_by_zero); end
    wait_done(lat);
    checks += 2;
    if (quotient !== 16'd3 || remainder !== 8'd1) begin
      errors++; $display("FAIL dz_next got %0d r%0d want 3 r1", quotient, remainder);
    end
    if (div_by_zero !== 1'b0) begin errors++; $display("FAIL dz_next_flag got %b want 0", div_by_zero); end
    idle(2);
  endtask

  task automatic test_ignore_start;
    int lat;
    start_op(16'd50000, 8'd3);
    idle(4);
    start = 1'b1; dividend = 16'd10; divisor = 8'd2;
    idle(1);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL ign_busy got %b want 1", busy); end
    wait_done(lat);
    checks += 3;
    if (lat != 11) begin errors++; $display("FAIL ign_lat got %0d want 11", lat); end
    if (quotient !== 16'd16666) begin errors++; $display("FAIL ign_quot got %0d want 16666", quotient); end
    if (remainder !== 8'd2) begin errors++; $display("FAIL ign_rem got %0d want 2", remainder); end
    idle(2);
  endtask

  task automatic test_reset_abort;
    int  lat;
    logic seen;
    start_op(16'd12345, 8'd10);
    idle(8);
    reset = 1'b1;
    idle(1);
    checks += 5;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", done); end
    if (quotient !== 16'd0) begin errors++; $display("FAIL abort_quot got %0d want 0", quotient); end
    if (remainder !== 8'd0) begin errors++; $display("FAIL abort_rem got %0d want 0", remainder); end
    if (div_by_zero !== 1'b0) begin errors++; $display("FAIL abort_dbz got %b want 0", div_by_zero); end
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      idle(1);
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL abort_quiet got activity want none"); end
    start_op(16'd12345, 8'd10);
    wait_done(lat);
    checks += 3;
    if (lat != 16) begin errors++; $display("FAIL abort_lat got %0d want 16", lat); end
    if (quotient !== 16'd1234) begin errors++; $display("FAIL abort_quot2 got %0d want 1234", quotient); end
    if (remainder !== 8'd5) begin errors++; $display("FAIL abort_rem2 got %0d want 5", remainder); end
    idle(1);
  endtask

  task automatic test_random;
    int lat, a, b, elat;
    for (int i = 0; i < 200; i++) begin
      a = int'($urandom_range(0, 65535));
      b = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 255));
      elat = (b == 0) ? ZLAT : 16;
      start_op(16'(a), 8'(b));
      wait_done(lat);
      checks += 4;
      if (lat != elat) begin errors++; $display("FAIL rnd_lat a=%0d b=%0d got %0d want %0d", a, b, lat, elat); end
      if (quotient !== m_quot(a, b)) begin errors++; $display("FAIL rnd_quot a=%0d b=%0d got %0d want %0d", a, b, quotient, m_quot(a, b)); end
      if (remainder !== m_rem(a, b)) begin errors++; $display("FAIL rnd_rem a=%0d b=%0d got %0d want %0d", a, b, remainder, m_rem(a, b)); end
      if (div_by_zero !== (b == 0)) begin errors++; $display("FAIL rnd_dbz a=%0d b=%0d got %b want %b", a, b, div_by_zero, b == 0); end
      idle(int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_round_trip;
    int lat, a, b;
    for (int i = 0; i < 1000; i++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(1, 255));
      start_op(16'(a * b), 8'(b));
      wait_done(lat);
      checks += 3;
      if (lat != 16) begin errors++; $display("FAIL rt_lat a=%0d b=%0d got %0d want 16", a, b, lat); end
      if (quotient !== 16'(a)) begin errors++; $display("FAIL rt_quot a=%0d b=%0d got %0d want %0d", a, b, quotient, a); end
      if (remainder !== 8'd0) begin errors++; $display("FAIL rt_rem a=%0d b=%0d got %0d want 0", a, b, remainder); end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; dividend = 16'd0; divisor = 8'd0;
    test_reset;
    test_basic;
    test_back_to_back;
    test_div_zero;
    test_ignore_start;
    test_reset_abort;
    test_random;
    test_round_trip;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
